// File: rtl/sample_drain_fifo_if.sv
// rtl/sample_drain_fifo_if.sv - producer/consumer bundle for the sample drain FIFO
interface sample_drain_fifo_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
);
  logic                  validIn;
  logic [WIDTH-1:0]      dataIn;
  logic                  readReq;
  logic                  validOut;
  logic [WIDTH-1:0]      dataOut;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;

  // The side driving samples in and pulling words out.
  modport master (
    output validIn, dataIn, readReq,
    input  validOut, dataOut, empty, full, count, overflow
  );

  // The FIFO itself.
  modport slave (
    input  validIn, dataIn, readReq,
    output validOut, dataOut, empty, full, count, overflow
  );
endinterface

// File: rtl/sample_drain_fifo.sv
// rtl/sample_drain_fifo.sv - burst-absorbing sample FIFO with request/valid drain and sticky overflow
module sample_drain_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input logic                clock,
  input logic                reset,
  sample_drain_fifo_if.slave bus
);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem [0:(1 << DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [DEPTH_LOG2:0]   countQ;
  logic [DEPTH_LOG2:0]   countNext;
  logic                  emptyQ;
  logic                  fullQ;
  logic                  overflowQ;
  logic                  validOutQ;
  logic [WIDTH-1:0]      dataOutQ;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // Pop and push are judged on registered state; a pop frees the slot a full-time write needs.
  always_comb begin
    pop       = bus.readReq && !emptyQ;
    push      = bus.validIn && (!fullQ || pop);
    drop      = bus.validIn && fullQ && !pop;
    countNext = countQ;
    if (push && !pop) begin
      countNext = countQ + CNT_ONE;
    end else if (pop && !push) begin
      countNext = countQ - CNT_ONE;
    end
  end

  // Storage array has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wrPtr] <= bus.dataIn;
    end
  end

  // Pointers, fill state, drain output and sticky overflow all move on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      countQ    <= '0;
      emptyQ    <= 1'b1;
      fullQ     <= 1'b0;
      overflowQ <= 1'b0;
      validOutQ <= 1'b0;
      dataOutQ  <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (pop) begin
        rdPtr    <= rdPtr + PTR_ONE;
        dataOutQ <= mem[rdPtr];
      end
      validOutQ <= pop;
      countQ    <= countNext;
      emptyQ    <= (countNext == '0);
      fullQ     <= (countNext == CNT_FULL);
      if (drop) begin
        overflowQ <= 1'b1;
      end
    end
  end

  assign bus.validOut = validOutQ;
  assign bus.dataOut  = dataOutQ;
  assign bus.empty    = emptyQ;
  assign bus.full     = fullQ;
  assign bus.count    = countQ;
  assign bus.overflow = overflowQ;
endmodule

// File: tb/tb_sample_drain_fifo.sv
// tb/tb_sample_drain_fifo.sv - scoreboard bench for sample_drain_fifo
module tb_sample_drain_fifo;
  typedef struct {
    logic [31:0] data;
    int          expCyc;
  } sbEntry_t;

  logic     clock;
  logic     reset;
  int       checks;
  int       errors;
  int       cyc;
  sbEntry_t sb[$];

  sample_drain_fifo_if #(.WIDTH(32), .DEPTH_LOG2(4)) bus ();

  sample_drain_fifo #(.WIDTH(32), .DEPTH_LOG2(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every validOut pulse must match the oldest expected word.
  always @(negedge clock) begin
    if (!reset && bus.validOut === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected no output (cycle %0d)", bus.dataOut, cyc);
      end else begin
        sbEntry_t e;
        e = sb.pop_front();
        chk("drain_data", {32'd0, bus.dataOut}, {32'd0, e.data});
        if (e.expCyc >= 0) chk("drain_latency", cyc, e.expCyc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pushWord(input logic [31:0] d, input bit expectOut, input bit timed);
    sbEntry_t e;
    bus.validIn = 1'b1;
    bus.dataIn  = d;
    if (expectOut) begin
      e.data   = d;
      e.expCyc = timed ? cyc + 2 : -1;
      sb.push_back(e);
    end
  endtask

  task automatic syncReset();
    bus.validIn = 1'b0;
    bus.readReq = 1'b0;
    reset = 1'b1;
    sb.delete();
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    reset  = 1'b1;
    bus.validIn = 1'b0;
    bus.dataIn  = '0;
    bus.readReq = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state, then readReq on an empty FIFO.
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_validOut", bus.validOut, 0);
    chk("rst_dataOut", bus.dataOut, 0);
    chk("rst_overflow", bus.overflow, 0);
    bus.readReq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_validOut", bus.validOut, 0);
      chk("idle_empty", bus.empty, 1);
      chk("idle_count", bus.count, 0);
      chk("idle_dataOut", bus.dataOut, 0);
    end
    bus.readReq = 1'b0;

    // Three words in, three out.
    pushWord(32'h11111111, 1, 0); step();
    chk("t2_empty_after_first", bus.empty, 0);
    pushWord(32'h22222222, 1, 0); step();
    pushWord(32'h33333333, 1, 0); step();
    bus.validIn = 1'b0;
    chk("t2_count3", bus.count, 3);
    bus.readReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_count_drain", bus.count, 2 - i);
    end
    bus.readReq = 1'b0;
    step();
    chk("t2_empty_end", bus.empty, 1);
    chk("t2_sb_empty", sb.size(), 0);

    // Fill to 16, overflow write dropped, drain in order.
    for (int i = 0; i < 16; i++) begin
      pushWord(i, 1, 0);
      step();
    end
    bus.validIn = 1'b0;
    chk("t3_full", bus.full, 1);
    chk("t3_count16", bus.count, 16);
    chk("t3_overflow_pre", bus.overflow, 0);
    pushWord(32'h0000DEAD, 0, 0); step();
    bus.validIn = 1'b0;
    chk("t3_overflow", bus.overflow, 1);
    chk("t3_count_hold", bus.count, 16);
    bus.readReq = 1'b1;
    for (int i = 0; i < 16; i++) step();
    bus.readReq = 1'b0;
    step();
    chk("t3_empty", bus.empty, 1);
    chk("t3_overflow_sticky", bus.overflow, 1);
    chk("t3_sb_empty", sb.size(), 0);

    // Full with simultaneous push and pop for 20 cycles.
    syncReset();
    chk("t4_overflow_cleared", bus.overflow, 0);
    for (int i = 0; i < 16; i++) begin
      pushWord(32'h100 + i, 1, 0);
      step();
    end
    bus.readReq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pushWord(32'h200 + i, 1, 0);
      step();
      chk("t4_count", bus.count, 16);
      chk("t4_full", bus.full, 1);
      chk("t4_overflow", bus.overflow, 0);
    end
    bus.validIn = 1'b0;
    for (int i = 0; i < 16; i++) step();
    bus.readReq = 1'b0;
    step();
    chk("t4_empty", bus.empty, 1);
    chk("t4_sb_empty", sb.size(), 0);

    // 40 words streamed through with readReq held: wraps twice, fixed latency.
    bus.readReq = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pushWord(32'h3000 + i, 1, 1);
      step();
      chk("t5_count_le1", bus.count <= 1, 1);
    end
    bus.validIn = 1'b0;
    step();
    step();
    bus.readReq = 1'b0;
    step();
    chk("t5_empty", bus.empty, 1);
    chk("t5_sb_empty", sb.size(), 0);
    chk("t5_overflow", bus.overflow, 0);

    // Asynchronous reset mid-cycle while a pop is being presented.
    for (int i = 0; i < 5; i++) begin
      pushWord(32'h4000 + i, i == 0, 0);
      step();
    end
    bus.validIn = 1'b0;
    bus.readReq = 1'b1;
    step();
    bus.readReq = 1'b0;
    chk("t6_count_pre", bus.count, 4);
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("t6_count", bus.count, 0);
    chk("t6_empty", bus.empty, 1);
    chk("t6_validOut", bus.validOut, 0);
    chk("t6_overflow", bus.overflow, 0);
    chk("t6_dataOut", bus.dataOut, 0);
    reset = 1'b0;
    bus.readReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_valid", bus.validOut, 0);
    end
    bus.readReq = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sample_drain_fifo.md
Name: sample_drain_fifo

Overview:
Read-side buffer for sample streams produced by the fixed-latency delay pipeline. The producer pushes validIn/dataIn with no backpressure. A downstream consumer (SRAM writer, RLE encoder or serial transmitter) pulls words with a request/valid handshake at its own pace. The block absorbs bursts, reports fill state, and flags lost samples instead of stalling the capture path.

Parameters:
WIDTH, 32, sample word width in bits.
DEPTH_LOG2, 4, log2 of storage depth; DEPTH = 2**DEPTH_LOG2 entries (16 default, legal 2..8).

Ports:
clock  input  1  single system clock; all logic rising-edge.
reset  input  1  asynchronous, active-high reset; clears all state immediately.
validIn  input  1  write strobe; dataIn is pushed when high.
dataIn  input  WIDTH  sample word to store.
readReq  input  1  consumer requests one word this cycle.
validOut  output  1  one-cycle pulse: dataOut holds a popped word.
dataOut  output  WIDTH  popped word; holds its last value when validOut is low.
empty  output  1  no stored words.
full  output  1  count == DEPTH.
count  output  DEPTH_LOG2+1  number of stored words.
overflow  output  1  sticky flag: at least one write was dropped.

Behaviour:
- Reset, asynchronous: write/read pointers = 0, count = 0, empty = 1, full = 0, validOut = 0, dataOut = 0, overflow = 0. Applies mid-operation; stored words are discarded.
- Storage: DEPTH x WIDTH register/LUT-RAM array. Pointers are DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0. count is tracked explicitly, DEPTH_LOG2+1 bits, so full and empty are unambiguous.
- Write accepted when validIn=1 AND (not full OR pop this cycle). Data is stored at wrPtr and wrPtr increments.
- Write when full with no pop: word dropped, pointers unchanged, overflow set to 1 and held until reset.
- Pop occurs when readReq=1 AND not empty, judged on the registered state at the clock edge. At that edge dataOut <= mem[rdPtr], rdPtr increments, and validOut = 1 for exactly the next cycle.
- readReq while empty is ignored: no pop, validOut = 0, no error flag.
- Latency: a word written at edge N is visible at edge N+1 (empty deasserts). The earliest pop edge is N+1, so dataOut/validOut appear 2 cycles after validIn.
- Simultaneous push and pop:
  - count unchanged.
  - When full, the pop frees a slot and the write is accepted; overflow is not set.
  - When empty, only the push happens; readReq is ignored because the word was not yet stored.
- count/empty/full are registered and updated on the same edge as the pointers: +1 on push only, -1 on pop only.
- Sustained operation: back-to-back readReq with continuous validIn gives one word per clock and steady-state count.
- Order is strictly FIFO. No reordering; no word is duplicated or lost except dropped overflow writes.

Test Plan:
- Reset then idle, readReq=1 for 5 cycles -> validOut stays 0, empty=1, count=0, dataOut=0.
- Push 0x11111111,0x22222222,0x33333333 on consecutive cycles, then readReq for 3 cycles -> validOut pulses with dataOut 0x11111111,0x22222222,0x33333333 in order; count 3->0; empty=1 at the end.
- Push 16 words 0..15 (DEPTH=16) -> full=1, count=16. Push 0xDEAD with no read -> overflow=1, count stays 16. Drain 16 -> values 0..15; 0xDEAD never appears.
- Fill to 16, then validIn=1 and readReq=1 together for 20 cycles -> one word out per cycle in order, count stays 16, overflow stays 0.
- Write 40 words with readReq held high throughout -> pointers wrap twice; all 40 values come out in order, each 2 cycles after its write; count never exceeds 1.
- Push 5 words, assert reset asynchronously mid-cycle -> outputs clear before the next edge: count=0, empty=1, validOut=0, overflow=0. A following readReq gives no validOut.
